tdc_shot_scheduler: RTL
=======================

// Module: tdc_shot_scheduler
// PURPOSE
//  Sequences TDC measurement shots for one frame: issues TDC_start pulses at a programmed period,
//  gates the histogram (his_en), and tracks each shot's end via the TDC output stream's last beat.
//  Sits between core logic and tdc_top/histogram; replaces free-running start generation with
//  frame-bounded, counted shots and per-shot timeout.
// PARAMETERS
//  START_W   4    TDC_start pulse width in clk_i cycles (>=1)
//  PER_W     20   width of period/offset counters
//  SHOT_W    16   width of shot counter
// PORTS
//  clk_i        in   1       logic clock
//  rst_auto     in   1       asynchronous, active-low reset
//  cfg_en       in   1       scheduler enable; low aborts any frame
//  frame_req    in   1       1-cycle pulse: start frame (honoured only in IDLE with cfg_en=1)
//  cfg_offset   in   PER_W   cycles from accept to first shot
//  cfg_period   in   PER_W   shot period in cycles
//  cfg_shots    in   SHOT_W  shots per frame (0 treated as 1)
//  tdc_ovalid   in   1       TDC_Ovalid
//  tdc_oready   in   1       TDC_Oready (consumer ready)
//  tdc_olast    in   1       TDC_Olast
//  tdc_start    out  1       TDC_start to tdc_top
//  his_en       out  1       histogram enable
//  busy         out  1       high in any state but IDLE
//  shot_cnt     out  SHOT_W  shots completed or timed out in current frame
//  frame_done   out  1       1-cycle pulse: frame complete
//  frame_abort  out  1       1-cycle pulse: frame killed by cfg_en low
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0.
//  Config (offset, period, shots) latched on frame accept; changes mid-frame are ignored.
//  Effective period = max(cfg_period, START_W+2).
//  States:
//   IDLE : frame_req & cfg_en -> ARM; shot_cnt cleared; latch config.
//   ARM  : wait cfg_offset cycles (0 -> FIRE next cycle) -> FIRE.
//   FIRE : tdc_start=1 for exactly START_W cycles; period counter p_cnt=0 on first FIRE cycle
//          and increments every cycle of the shot -> WAIT.
//   WAIT : end-of-shot = tdc_ovalid & tdc_oready & tdc_olast, or p_cnt==period-1 (timeout).
//          Beats with tdc_olast=0 are ignored. On end-of-shot shot_cnt++; if shot_cnt+1==shots
//          -> DONE, else GAP. A last beat on the final period cycle counts as completed, not timed out.
//          Olast beats seen during FIRE are taken as the end of that shot.
//   GAP  : hold until p_cnt==period-1 -> FIRE (next shot starts exactly one period after the last).
//          A timeout exits WAIT straight to FIRE.
//   DONE : frame_done=1 for one cycle -> IDLE.
//  his_en: 1 from the first FIRE cycle through the DONE cycle; 0 otherwise.
//  Shot-to-shot TDC_start rising edges are exactly period cycles apart.
//  cfg_en low in any non-IDLE state: next cycle -> IDLE, tdc_start/his_en drop,
//   frame_abort pulses 1 cycle, shot_cnt holds, no frame_done.
//  frame_req while busy: ignored (no queueing). frame_req together with cfg_en rising: accepted.
//  Counters saturate, never wrap; shot_cnt never exceeds shots.
//  Async reset mid-frame: immediate IDLE, outputs 0.
// CONFIGURATION
//  TDC_SCHED_MISS_CNT_EN defined: adds output miss_cnt [SHOT_W-1:0], counting shots ended by
//   timeout in the current frame; cleared on frame accept, held after DONE/abort; reset 0.
//  Not defined: no miss_cnt port or logic; timeout behaviour unchanged.
// TESTING
//  offset=10, period=100, shots=3, olast beat at p_cnt=40 each shot -> 3 start pulses of 4 cycles,
//   rising edges 100 apart, first at 11 cycles after accept; frame_done 1 cycle; shot_cnt=3.
//  Same config, no olast ever -> 3 timeouts; frame_done at accept+11+300; miss_cnt=3 if macro on.
//  olast with tdc_oready=0 at p_cnt=40, ready at p_cnt=45 -> shot ends at p_cnt=45; ovalid beats
//   without olast ignored.
//  cfg_en dropped during shot 2 WAIT -> frame_abort pulse, tdc_start=his_en=0 next cycle,
//   shot_cnt=1, no frame_done.
//  period=2, START_W=4 -> effective period 6; shots=0 -> exactly one shot.
//  frame_req while busy ignored; rst_auto low mid-FIRE -> tdc_start=0 immediately, IDLE.

Source files
------------

// File: rtl/tdc_shot_scheduler.sv
// Frame-bounded TDC shot sequencer: counted start pulses at a fixed period, histogram gating, per-shot timeout.
// Optional feature: define TDC_SCHED_MISS_CNT_EN to add the miss_cnt (timed-out shots) output.
module tdc_shot_scheduler #(
   parameter int START_W = 4,
   parameter int PER_W   = 20,
   parameter int SHOT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_auto,
   input  logic              cfg_en,
   input  logic              frame_req,
   input  logic [PER_W-1:0]  cfg_offset,
   input  logic [PER_W-1:0]  cfg_period,
   input  logic [SHOT_W-1:0] cfg_shots,
   input  logic              tdc_ovalid,
   input  logic              tdc_oready,
   input  logic              tdc_olast,
   output logic              tdc_start,
   output logic              his_en,
   output logic              busy,
   output logic [SHOT_W-1:0] shot_cnt,
   output logic              frame_done,
   output logic              frame_abort
`ifdef TDC_SCHED_MISS_CNT_EN
   ,output logic [SHOT_W-1:0] miss_cnt
`endif
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_ARM  = 3'd1;
   localparam logic [2:0] S_FIRE = 3'd2;
   localparam logic [2:0] S_WAIT = 3'd3;
   localparam logic [2:0] S_GAP  = 3'd4;
   localparam logic [2:0] S_DONE = 3'd5;

   localparam logic [PER_W-1:0] MIN_PER   = PER_W'(START_W + 2);
   localparam logic [PER_W-1:0] FIRE_LAST = PER_W'(START_W - 1);

   logic [2:0]        state_r;
   logic [2:0]        state_nxt_s;
   logic [PER_W-1:0]  off_r;
   logic [PER_W-1:0]  per_last_r;
   logic [PER_W-1:0]  arm_cnt_r;
   logic [PER_W-1:0]  p_cnt_r;
   logic [SHOT_W-1:0] shots_last_r;
   logic              fire_hit_r;
   logic [PER_W-1:0]  eff_per_s;
   logic              beat_s;
   logic              accept_s;
   logic              abort_s;
   logic              per_end_s;
   logic              last_shot_s;
   logic              shot_end_s;

   // Next-state decode; abort from cfg_en outranks every transition except DONE.
   always_comb begin
      beat_s      = tdc_ovalid & tdc_oready & tdc_olast;
      accept_s    = (state_r == S_IDLE) & frame_req & cfg_en;
      abort_s     = ~cfg_en & (state_r != S_IDLE) & (state_r != S_DONE);
      per_end_s   = (p_cnt_r == per_last_r);
      last_shot_s = (shot_cnt == shots_last_r);
      eff_per_s   = (cfg_period > MIN_PER) ? cfg_period : MIN_PER;
      shot_end_s  = 1'b0;
      state_nxt_s = state_r;
      if (abort_s) begin
         state_nxt_s = S_IDLE;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (accept_s) state_nxt_s = S_ARM;
               else          state_nxt_s = S_IDLE;
            end
            S_ARM: begin
               if (arm_cnt_r == off_r) state_nxt_s = S_FIRE;
               else                    state_nxt_s = S_ARM;
            end
            S_FIRE: begin
               if (p_cnt_r == FIRE_LAST) begin
                  if (fire_hit_r | beat_s) begin
                     shot_end_s  = 1'b1;
                     state_nxt_s = last_shot_s ? S_DONE : S_GAP;
                  end else begin
                     state_nxt_s = S_WAIT;
                  end
               end else begin
                  state_nxt_s = S_FIRE;
               end
            end
            S_WAIT: begin
               // A period-end exit goes straight to FIRE so start edges stay one period apart.
               if (beat_s | per_end_s) begin
                  shot_end_s = 1'b1;
                  if (last_shot_s)    state_nxt_s = S_DONE;
                  else if (per_end_s) state_nxt_s = S_FIRE;
                  else                state_nxt_s = S_GAP;
               end else begin
                  state_nxt_s = S_WAIT;
               end
            end
            S_GAP: begin
               if (per_end_s) state_nxt_s = S_FIRE;
               else           state_nxt_s = S_GAP;
            end
            S_DONE:  state_nxt_s = S_IDLE;
            default: state_nxt_s = S_IDLE;
         endcase
      end
   end

   // State and registered outputs, aligned with the state they describe.
   always_ff @(posedge clk_i or negedge rst_auto) begin
      if (!rst_auto) begin
         state_r     <= S_IDLE;
         tdc_start   <= 1'b0;
         his_en      <= 1'b0;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
         frame_abort <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         tdc_start   <= (state_nxt_s == S_FIRE);
         his_en      <= (state_nxt_s == S_FIRE) | (state_nxt_s == S_WAIT) |
                        (state_nxt_s == S_GAP)  | (state_nxt_s == S_DONE);
         busy        <= (state_nxt_s != S_IDLE);
         frame_done  <= (state_nxt_s == S_DONE);
         frame_abort <= abort_s;
      end
   end

   // Frame configuration snapshot taken on accept.
   always_ff @(posedge clk_i or negedge rst_auto) begin
      if (!rst_auto) begin
         off_r        <= {PER_W{1'b0}};
         per_last_r   <= {PER_W{1'b0}};
         shots_last_r <= {SHOT_W{1'b0}};
      end else if (accept_s) begin
         off_r        <= cfg_offset;
         per_last_r   <= eff_per_s - PER_W'(1);
         shots_last_r <= (cfg_shots == {SHOT_W{1'b0}}) ? {SHOT_W{1'b0}} : cfg_shots - SHOT_W'(1);
      end else begin
         off_r        <= off_r;
         per_last_r   <= per_last_r;
         shots_last_r <= shots_last_r;
      end
   end

   // Offset, period and shot counters; all saturate.
   always_ff @(posedge clk_i or negedge rst_auto) begin
      if (!rst_auto) begin
         arm_cnt_r  <= {PER_W{1'b0}};
         p_cnt_r    <= {PER_W{1'b0}};
         fire_hit_r <= 1'b0;
         shot_cnt   <= {SHOT_W{1'b0}};
      end else begin
         if (accept_s)                                        arm_cnt_r <= {PER_W{1'b0}};
         else if (state_r == S_ARM && arm_cnt_r != '1)        arm_cnt_r <= arm_cnt_r + PER_W'(1);
         else                                                 arm_cnt_r <= arm_cnt_r;

         if (state_nxt_s == S_FIRE && state_r != S_FIRE)      p_cnt_r <= {PER_W{1'b0}};
         else if ((state_r == S_FIRE || state_r == S_WAIT || state_r == S_GAP) && p_cnt_r != '1)
                                                              p_cnt_r <= p_cnt_r + PER_W'(1);
         else                                                 p_cnt_r <= p_cnt_r;

         fire_hit_r <= (state_r == S_FIRE) & (fire_hit_r | beat_s);

         if (accept_s)                                        shot_cnt <= {SHOT_W{1'b0}};
         else if (shot_end_s && shot_cnt != '1)               shot_cnt <= shot_cnt + SHOT_W'(1);
         else                                                 shot_cnt <= shot_cnt;
      end
   end

`ifdef TDC_SCHED_MISS_CNT_EN
   // Timed-out shots: a WAIT exit without a last beat.
   always_ff @(posedge clk_i or negedge rst_auto) begin
      if (!rst_auto) begin
         miss_cnt <= {SHOT_W{1'b0}};
      end else if (accept_s) begin
         miss_cnt <= {SHOT_W{1'b0}};
      end else if (shot_end_s && state_r == S_WAIT && !beat_s && miss_cnt != '1) begin
         miss_cnt <= miss_cnt + SHOT_W'(1);
      end else begin
         miss_cnt <= miss_cnt;
      end
   end
`endif

endmodule
